// File: rtl/tile_state_control.sv
// Tile-looping read/process/write sequencer with per-phase watchdog and abort.
// Outputs are registered and decoded from the next state, so they change on the same edge as the state.
module tile_state_control #(
    parameter int TILE_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              rd_done,
    input  logic              finish,
    input  logic              wr_done,
    output logic              rd_en,
    output logic              enable,
    output logic              wr_en,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_phase
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PROC,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [TILE_W-1:0] r_cnt;
    logic [TILE_W-1:0] r_idx;
    logic [TILE_W-1:0] w_nxt_cnt;
    logic [TILE_W-1:0] w_nxt_idx;
    logic [TO_W-1:0]   r_wdog;
    logic [1:0]        r_err_phase;
    logic [1:0]        w_nxt_eph;
    logic              r_rd_en;
    logic              r_enable;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_hs;
    logic              w_in_phase;
    logic              w_tmo;

    always_comb begin
        w_hs = 1'b0;
        case (r_state)
            S_READ:  w_hs = rd_done;
            S_PROC:  w_hs = finish;
            S_WRITE: w_hs = wr_done;
            default: w_hs = 1'b0;
        endcase
    end

    assign w_in_phase = (r_state == S_READ) || (r_state == S_PROC) || (r_state == S_WRITE);
    // Terminal count is one below TIMEOUT-1 so ERROR lands TIMEOUT-1 edges after phase entry.
    assign w_tmo      = w_in_phase && !w_hs && (r_wdog == TO_W'(TIMEOUT - 2));

    always_comb begin
        w_nxt     = r_state;
        w_nxt_idx = r_idx;
        w_nxt_cnt = r_cnt;
        w_nxt_eph = r_err_phase;
        if (abort) begin
            w_nxt     = S_IDLE;
            w_nxt_eph = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_nxt_cnt = num_tiles;
                        w_nxt_idx = '0;
                        w_nxt     = (num_tiles == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (w_hs) begin
                        w_nxt = S_PROC;
                    end else if (w_tmo) begin
                        w_nxt     = S_ERROR;
                        w_nxt_eph = 2'd1;
                    end
                end
                S_PROC: begin
                    if (w_hs) begin
                        w_nxt = S_WRITE;
                    end else if (w_tmo) begin
                        w_nxt     = S_ERROR;
                        w_nxt_eph = 2'd2;
                    end
                end
                S_WRITE: begin
                    if (w_hs) begin
                        if (r_idx == r_cnt - TILE_W'(1)) begin
                            w_nxt = S_DONE;
                        end else begin
                            w_nxt_idx = r_idx + TILE_W'(1);
                            w_nxt     = S_READ;
                        end
                    end else if (w_tmo) begin
                        w_nxt     = S_ERROR;
                        w_nxt_eph = 2'd3;
                    end
                end
                S_DONE:  w_nxt = S_IDLE;
                S_ERROR: w_nxt = S_ERROR;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wdog      <= '0;
            r_err_phase <= 2'd0;
            r_rd_en     <= 1'b0;
            r_enable    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= w_nxt_cnt;
            r_idx       <= w_nxt_idx;
            r_err_phase <= w_nxt_eph;
            if ((w_nxt != r_state) || !w_in_phase) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + TO_W'(1);
            end
            r_rd_en  <= (w_nxt == S_READ);
            r_enable <= (w_nxt == S_PROC);
            r_wr_en  <= (w_nxt == S_WRITE);
            r_busy   <= (w_nxt == S_READ) || (w_nxt == S_PROC) || (w_nxt == S_WRITE);
            r_done   <= (w_nxt == S_DONE);
            r_err    <= (w_nxt == S_ERROR);
        end
    end

    assign rd_en     = r_rd_en;
    assign enable    = r_enable;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_phase = r_err_phase;
    assign tile_idx  = r_idx;

endmodule

// File: tb/tb_tile_state_control.sv
// Directed bench: a cycle-by-cycle expected trace is built from the tile/phase schedule and checked every cycle.
module tb_tile_state_control;

    localparam int TW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [TW-1:0] num_tiles;
    logic          rd_done;
    logic          finish;
    logic          wr_done;
    logic          rd_en;
    logic          enable;
    logic          wr_en;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_phase;

    tile_state_control #(.TILE_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_tiles(num_tiles),
        .rd_done(rd_done), .finish(finish), .wr_done(wr_done),
        .rd_en(rd_en), .enable(enable), .wr_en(wr_en), .tile_idx(tile_idx),
        .busy(busy), .done(done), .err(err), .err_phase(err_phase)
    );

    always #5 clk = ~clk;

    // Phase label the DUT should show during the current cycle.
    typedef enum int {K_I, K_R, K_P, K_W, K_D, K_E} kind_t;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_rd, n_en, n_wr, n_busy, n_done;
    bit            e_vld = 1'b0;
    kind_t         e_kind = K_I;
    logic [TW-1:0] e_idx = '0;
    logic [1:0]    e_eph = 2'd0;
    logic [TW-1:0] cur_idx = '0;

    // {rd_en, enable, wr_en, busy, done, err, err_phase}
    function automatic logic [7:0] exp_bits(kind_t k, logic [1:0] eph);
        case (k)
            K_R:     return 8'b1001_0000;
            K_P:     return 8'b0101_0000;
            K_W:     return 8'b0011_0000;
            K_D:     return 8'b0000_1000;
            K_E:     return {6'b000001, eph};
            default: return 8'b0000_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (e_vld) begin
            logic [7:0] got;
            logic [7:0] want;
            got  = {rd_en, enable, wr_en, busy, done, err, err_phase};
            want = exp_bits(e_kind, e_eph);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, got, want);
            end
            n_cmp++;
            if (tile_idx !== e_idx) begin
                n_fail++;
                $display("FAIL cycle_tile_idx t=%0t got=%0d want=%0d", $time, tile_idx, e_idx);
            end
            n_rd   += int'(rd_en);
            n_en   += int'(enable);
            n_wr   += int'(wr_en);
            n_busy += int'(busy);
            n_done += int'(done);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clr_tally();
        n_rd = 0; n_en = 0; n_wr = 0; n_busy = 0; n_done = 0;
    endtask

    // Declare the expected phase/index of the coming cycle and the inputs driven in it.
    task automatic step(input kind_t k, input logic [TW-1:0] idx, input logic s, input logic a,
                        input logic rd, input logic fi, input logic wd);
        @(posedge clk);
        #1;
        e_vld = 1'b1; e_kind = k; e_idx = idx;
        start = s; abort = a; rd_done = rd; finish = fi; wr_done = wd;
    endtask

    // Full run: each phase lasts (delay+1) cycles, handshake on its last cycle.
    task automatic run(input int n, input int dr, input int dp, input int dw, input bit chg, input bit stray);
        num_tiles = TW'(n);
        step(K_I, cur_idx, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (n == 0) begin
            step(K_D, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cur_idx = '0;
            return;
        end
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c <= dr; c++) begin
                step(K_R, TW'(t), stray, 1'b0, (c == dr), stray, stray);
                if (chg) num_tiles = TW'(n + 3 + c);
            end
            for (int c = 0; c <= dp; c++)
                step(K_P, TW'(t), stray, 1'b0, stray, (c == dp), stray);
            for (int c = 0; c <= dw; c++)
                step(K_W, TW'(t), stray, 1'b0, stray, stray, (c == dw));
        end
        step(K_D, TW'(n - 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_idx = TW'(n - 1);
    endtask

    task automatic idle();
        step(K_I, cur_idx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Stall phase ph (1=READ, 2=PROC, 3=WRITE) until the watchdog fires, then try start and abort.
    task automatic tmo(input int ph);
        kind_t pk;
        pk = (ph == 1) ? K_R : ((ph == 2) ? K_P : K_W);
        e_eph = 2'(ph);
        num_tiles = TW'(1);
        step(K_I, cur_idx, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_idx = '0;
        if (ph > 1) step(K_R, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (ph > 2) step(K_P, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < TO - 1; c++) step(pk, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(K_E, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_err_phase", 32'(err_phase), 32'(ph));
        check("tmo_enables", 32'({rd_en, enable, wr_en}), 32'd0);
        repeat (3) step(K_E, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(K_E, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(K_I, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("abort_clears_err", 32'({err, err_phase}), 32'd0);
        e_eph = 2'd0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; rd_done = 1'b0; finish = 1'b0; wr_done = 1'b0;
        num_tiles = '0;
        clr_tally();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({rd_en, enable, wr_en, busy, done, err, err_phase}), 32'd0);
        check("reset_tile_idx", 32'(tile_idx), 32'd0);
        reset = 1'b0;
        idle();
        idle();

        // Single tile, 3-cycle phases
        clr_tally();
        run(1, 2, 2, 2, 1'b0, 1'b0);
        idle();
        check("single_rd_cycles", 32'(n_rd), 32'd3);
        check("single_en_cycles", 32'(n_en), 32'd3);
        check("single_wr_cycles", 32'(n_wr), 32'd3);
        check("single_done_pulses", 32'(n_done), 32'd1);

        // Four tiles, minimum latency, num_tiles changed mid-run, stray handshakes
        clr_tally();
        run(4, 0, 0, 0, 1'b1, 1'b1);
        idle();
        check("multi_busy_cycles", 32'(n_busy), 32'd12);
        check("multi_done_pulses", 32'(n_done), 32'd1);
        check("multi_last_idx", 32'(tile_idx), 32'd3);

        // Back-to-back single tile then zero tiles
        clr_tally();
        run(1, 0, 1, 0, 1'b0, 1'b0);
        run(0, 0, 0, 0, 1'b0, 1'b0);
        idle();
        check("b2b_busy_cycles", 32'(n_busy), 32'd4);
        check("b2b_done_pulses", 32'(n_done), 32'd2);
        clr_tally();
        run(0, 0, 0, 0, 1'b0, 1'b0);
        idle();
        check("zero_busy_cycles", 32'(n_busy), 32'd0);
        check("zero_done_pulses", 32'(n_done), 32'd1);

        // Watchdog in each phase
        tmo(2);
        idle();
        tmo(1);
        tmo(3);

        // Handshakes exactly on the watchdog terminal cycle
        run(1, TO - 2, TO - 2, TO - 2, 1'b0, 1'b0);
        idle();
        check("terminal_hs_no_err", 32'(err), 32'd0);

        // wr_done together with abort on the last tile
        clr_tally();
        num_tiles = TW'(1);
        step(K_I, cur_idx, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_idx = '0;
        step(K_R, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(K_P, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(K_W, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        check("abort_wr_done_no_done", 32'(n_done), 32'd0);

        // Largest count
        run(255, 0, 0, 0, 1'b0, 1'b0);
        idle();
        check("max_count_last_idx", 32'(tile_idx), 32'd254);

        // Asynchronous reset in WRITE of the second tile
        num_tiles = TW'(2);
        step(K_I, cur_idx, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(K_R, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(K_P, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(K_W, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(K_R, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(K_P, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(K_W, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        e_kind = K_I; e_idx = '0; cur_idx = '0;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'({rd_en, enable, wr_en, busy, done, err, err_phase}), 32'd0);
        check("async_reset_idx", 32'(tile_idx), 32'd0);
        idle();
        reset = 1'b0;
        idle();
        idle();
        run(2, 1, 0, 1, 1'b0, 1'b0);
        idle();

        e_vld = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
